raptor64_shift_pipe: RTL and testbench

Parametrised, pipelined shift/rotate unit for the Raptor64 execute stage. It replaces the single-cycle combinational shifter on timing-critical builds. It accepts one operation per cycle under a valid/ready handshake, spreads the log2(WID) shift levels over STAGES register stages, and returns results in order with a caller tag. It supports logical, arithmetic and rotate shifts, rotate-and-mask, and optional funnel shifts.

---
 rtl/raptor64_shift_pkg.sv | 25 ++
 rtl/raptor64_shift_stage.sv | 146 ++++++++++++++
 rtl/raptor64_shift_pipe.sv | 128 ++++++++++++
 tb/tb_raptor64_shift_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/raptor64_shift_pkg.sv
// Shared types and helpers for the Raptor64 pipelined shift/rotate unit.
// Funnel ops are built only when RAPTOR64_SHIFT_FUNNEL_EN is defined.
package raptor64_shift_pkg;

  typedef enum logic [2:0] {
    OP_SHL   = 3'd0,
    OP_SHRU  = 3'd1,
    OP_SHR   = 3'd2,
    OP_ROL   = 3'd3,
    OP_ROR   = 3'd4,
    OP_ROLAM = 3'd5,
    OP_FSHL  = 3'd6,
    OP_FSHR  = 3'd7
  } shift_op_e;

  // Number of binary rotate levels needed for a given operand width.
  function automatic int shift_levels(input int wid);
    return $clog2(wid);
  endfunction

  function automatic logic is_right(input shift_op_e op);
    return (op == OP_SHRU) || (op == OP_SHR) || (op == OP_ROR) || (op == OP_FSHR);
  endfunction

endpackage

// File: rtl/raptor64_shift_stage.sv
// One pipeline stage of the shift unit: a slice of rotate levels plus its valid/advance logic.
// The last stage also merges fill and mask; RAPTOR64_SHIFT_FUNNEL_EN adds the funnel operand path.
module raptor64_shift_stage
  import raptor64_shift_pkg::*;
#(
  parameter int WID   = 64,
  parameter int TAGW  = 6,
  parameter int FIRST = 0,
  parameter int CNT   = 1,
  parameter bit LAST  = 1'b0,
  localparam int AW   = shift_levels(WID)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  shift_op_e       in_op,
  input  logic [WID-1:0]  in_res,
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
  input  logic [WID-1:0]  in_c,
`endif
  input  logic [AW-1:0]   in_r,
  input  logic [WID-1:0]  in_fmask,
  input  logic            in_sign,
  input  logic [WID-1:0]  in_mask,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output shift_op_e       out_op,
  output logic [WID-1:0]  out_res,
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
  output logic [WID-1:0]  out_c,
`endif
  output logic [AW-1:0]   out_r,
  output logic [WID-1:0]  out_fmask,
  output logic            out_sign,
  output logic [WID-1:0]  out_mask,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err
);

  logic            valid_reg;
  logic            load;
  logic [WID-1:0]  res_reg, res_next;
  logic            err_reg, err_next;
  logic [TAGW-1:0] tag_reg;
  shift_op_e       op_reg;
  logic [AW-1:0]   r_reg;
  logic [WID-1:0]  fmask_reg;
  logic            sign_reg;
  logic [WID-1:0]  mask_reg;

  logic [WID-1:0]  a_lvl [0:CNT];
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
  logic [WID-1:0]  c_lvl [0:CNT];
  logic [WID-1:0]  c_reg;
`endif

  // A stage takes new data whenever it is empty or its contents move on this edge.
  assign load      = !valid_reg || out_ready;
  assign in_ready  = load;
  assign out_valid = valid_reg;

  assign a_lvl[0] = in_res;
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
  assign c_lvl[0] = in_c;
`endif

  for (genvar gi = 0; gi < CNT; gi++) begin : g_lvl
    localparam int SH = 1 << (FIRST + gi);
    assign a_lvl[gi+1] = in_r[FIRST+gi] ? ((a_lvl[gi] << SH) | (a_lvl[gi] >> (WID - SH)))
                                        : a_lvl[gi];
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
    assign c_lvl[gi+1] = in_r[FIRST+gi] ? ((c_lvl[gi] << SH) | (c_lvl[gi] >> (WID - SH)))
                                        : c_lvl[gi];
`endif
  end

  // Fill mask marks the bits that wrapped around; they are replaced by the fill source.
  always_comb begin
    res_next = a_lvl[CNT];
    err_next = 1'b0;
    if (LAST) begin
      case (in_op)
        OP_SHL, OP_SHRU: res_next = a_lvl[CNT] & ~in_fmask;
        OP_SHR:          res_next = (a_lvl[CNT] & ~in_fmask) | ({WID{in_sign}} & in_fmask);
        OP_ROLAM:        res_next = a_lvl[CNT] & in_mask;
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
        OP_FSHL, OP_FSHR: res_next = (a_lvl[CNT] & ~in_fmask) | (c_lvl[CNT] & in_fmask);
`else
        OP_FSHL, OP_FSHR: begin
          res_next = '0;
          err_next = 1'b1;
        end
`endif
        default:         res_next = a_lvl[CNT];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reg <= '0;
      tag_reg <= '0;
      err_reg <= 1'b0;
    end else if (load && in_valid) begin
      res_reg <= res_next;
      tag_reg <= in_tag;
      err_reg <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (load && in_valid) begin
      op_reg    <= in_op;
      r_reg     <= in_r;
      fmask_reg <= in_fmask;
      sign_reg  <= in_sign;
      mask_reg  <= in_mask;
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
      c_reg     <= c_lvl[CNT];
`endif
    end
  end

  assign out_op    = op_reg;
  assign out_res   = res_reg;
  assign out_r     = r_reg;
  assign out_fmask = fmask_reg;
  assign out_sign  = sign_reg;
  assign out_mask  = mask_reg;
  assign out_tag   = tag_reg;
  assign out_err   = err_reg;
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
  assign out_c     = c_reg;
`endif

endmodule

// File: rtl/raptor64_shift_pipe.sv
// Pipelined shift/rotate unit: STAGES register stages, in-order, tagged, valid/ready on both sides.
// Define RAPTOR64_SHIFT_FUNNEL_EN to execute FSHL/FSHR; otherwise they return err_o=1.
module raptor64_shift_pipe
  import raptor64_shift_pkg::*;
#(
  parameter int WID    = 64,
  parameter int STAGES = 2,
  parameter int TAGW   = 6,
  localparam int AW    = shift_levels(WID)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [WID-1:0]  a_i,
  input  logic [WID-1:0]  c_i,
  input  logic [AW-1:0]   amt_i,
  input  logic [WID-1:0]  mask_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [WID-1:0]  o_o,
  output logic [TAGW-1:0] tag_o,
  output logic            err_o
);

  localparam int PER = (AW + STAGES - 1) / STAGES;
  localparam logic [WID-1:0] ONES = '1;

  shift_op_e       op_in;
  logic [AW-1:0]   r_in;
  logic [WID-1:0]  fmask_in;

  logic            v_s     [0:STAGES];
  logic            rdy_s   [0:STAGES];
  shift_op_e       op_s    [0:STAGES];
  logic [WID-1:0]  res_s   [0:STAGES];
  logic [AW-1:0]   r_s     [0:STAGES];
  logic [WID-1:0]  fmask_s [0:STAGES];
  logic            sign_s  [0:STAGES];
  logic [WID-1:0]  mask_s  [0:STAGES];
  logic [TAGW-1:0] tag_s   [0:STAGES];
  logic            err_s   [1:STAGES];
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
  logic [WID-1:0]  c_s     [0:STAGES];
`else
  logic            c_unused;
  assign c_unused = ^c_i;
`endif

  assign op_in = shift_op_e'(op_i);

  // Right ops become a left rotate by (WID - amt) mod WID; FSHR at amt=0 keeps a.
  always_comb begin
    r_in     = is_right(op_in) ? (AW'(0) - amt_i) : amt_i;
    fmask_in = '0;
    case (op_in)
      OP_SHL, OP_FSHL:  fmask_in = ~(ONES << amt_i);
      OP_SHRU, OP_SHR:  fmask_in = ~(ONES >> amt_i);
      OP_FSHR:          fmask_in = (amt_i == '0) ? '0 : (ONES >> amt_i);
      default:          fmask_in = '0;
    endcase
  end

  assign v_s[0]     = in_valid_i;
  assign op_s[0]    = op_in;
  assign res_s[0]   = a_i;
  assign r_s[0]     = r_in;
  assign fmask_s[0] = fmask_in;
  assign sign_s[0]  = a_i[WID-1];
  assign mask_s[0]  = mask_i;
  assign tag_s[0]   = tag_i;
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
  assign c_s[0]     = c_i;
`endif

  assign rdy_s[STAGES] = out_ready_i;
  assign in_ready_o    = rdy_s[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int FIRST = gi * PER;
    localparam int LEFT  = (AW > FIRST) ? (AW - FIRST) : 0;
    localparam int CNT   = (LEFT > PER) ? PER : LEFT;

    raptor64_shift_stage #(
      .WID   (WID),
      .TAGW  (TAGW),
      .FIRST (FIRST),
      .CNT   (CNT),
      .LAST  (gi == STAGES - 1)
    ) u_stage (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .in_valid  (v_s[gi]),
      .in_ready  (rdy_s[gi]),
      .in_op     (op_s[gi]),
      .in_res    (res_s[gi]),
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
      .in_c      (c_s[gi]),
`endif
      .in_r      (r_s[gi]),
      .in_fmask  (fmask_s[gi]),
      .in_sign   (sign_s[gi]),
      .in_mask   (mask_s[gi]),
      .in_tag    (tag_s[gi]),
      .out_valid (v_s[gi+1]),
      .out_ready (rdy_s[gi+1]),
      .out_op    (op_s[gi+1]),
      .out_res   (res_s[gi+1]),
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
      .out_c     (c_s[gi+1]),
`endif
      .out_r     (r_s[gi+1]),
      .out_fmask (fmask_s[gi+1]),
      .out_sign  (sign_s[gi+1]),
      .out_mask  (mask_s[gi+1]),
      .out_tag   (tag_s[gi+1]),
      .out_err   (err_s[gi+1])
    );
  end

  assign out_valid_o = v_s[STAGES];
  assign o_o         = res_s[STAGES];
  assign tag_o       = tag_s[STAGES];
  assign err_o       = err_s[STAGES];

endmodule

// File: tb/tb_raptor64_shift_pipe.sv
// Self-checking bench for raptor64_shift_pipe (WID=64, STAGES=2); expectations follow
// RAPTOR64_SHIFT_FUNNEL_EN so the same bench covers both builds.
module tb_raptor64_shift_pipe;

  localparam int WID    = 64;
  localparam int STAGES = 2;
  localparam int TAGW   = 6;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [2:0]      op_i;
  logic [WID-1:0]  a_i;
  logic [WID-1:0]  c_i;
  logic [5:0]      amt_i;
  logic [WID-1:0]  mask_i;
  logic [TAGW-1:0] tag_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [WID-1:0]  o_o;
  logic [TAGW-1:0] tag_o;
  logic            err_o;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [WID-1:0]  o;
    logic            err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   emitted  = 0;
  bit   rand_rdy = 1'b0;

  always #5 clk = ~clk;

  raptor64_shift_pipe #(.WID(WID), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .c_i         (c_i),
    .amt_i       (amt_i),
    .mask_i      (mask_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .o_o         (o_o),
    .tag_o       (tag_o),
    .err_o       (err_o)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h required=%h", name, obs, exp);
    end
  endtask

  // Reference: direct wide-shift definitions of each op.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] c, input logic [5:0] amt,
                                        input logic [63:0] mask);
    logic [127:0] w;
    logic [63:0]  r;
    r = '0;
    case (op)
      3'd0: r = a << amt;
      3'd1: r = a >> amt;
      3'd2: r = $signed(a) >>> amt;
      3'd3: r = (a << amt) | (a >> (64 - amt));
      3'd4: r = (a >> amt) | (a << (64 - amt));
      3'd5: r = ((a << amt) | (a >> (64 - amt))) & mask;
      3'd6: begin w = {a, c} << amt; r = w[127:64]; end
      default: begin w = {a, c} >> amt; r = (amt == 6'd0) ? a : w[63:0]; end
    endcase
`ifndef RAPTOR64_SHIFT_FUNNEL_EN
    if (op >= 3'd6) return {1'b1, 64'd0};
`endif
    return {1'b0, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op; record its expectation at the edge where the handshake completes.
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] c,
                      input logic [5:0] amt, input logic [63:0] mask, input logic [5:0] tag,
                      input logic [63:0] eo, input logic ee);
    exp_t e;
    bit   done;
    done = 1'b0;
    op_i = op; a_i = a; c_i = c; amt_i = amt; mask_i = mask; tag_i = tag;
    in_valid_i = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      if (rand_rdy) out_ready_i = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      if (in_ready_o) begin
        e.tag = tag; e.o = eo; e.err = ee;
        sb.push_back(e);
        done = 1'b1;
      end
      step();
    end
    in_valid_i = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL send_timeout tag=%0d observed=stalled required=accepted", tag);
    end
  endtask

  task automatic send_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] c,
                            input logic [5:0] amt, input logic [63:0] mask, input logic [5:0] tag);
    logic [64:0] m;
    m = model(op, a, c, amt, mask);
    send(op, a, c, amt, mask, tag, m[63:0], m[64]);
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() != 0; n++) begin
      out_ready_i = rand_rdy ? ($urandom_range(0, 1) != 0) : 1'b1;
      @(negedge clk);
      step();
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      emitted++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL spurious_output tag=%0d observed=%h required=none", tag_o, o_o);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        $display("txn tag=%0d o=%h err=%0b", tag_o, o_o, err_o);
        chk("out_tag", 64'(tag_o), 64'(mon_e.tag));
        chk("out_o", o_o, mon_e.o);
        chk("out_err", 64'(err_o), 64'(mon_e.err));
      end
    end
  end

  initial begin
    int          accepts;
    int          base;
    logic [5:0]  t;
    logic [64:0] m1;
    logic [2:0]  rop;
    logic [5:0]  ramt;

    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = '0; a_i = '0; c_i = '0; amt_i = '0; mask_i = '0; tag_i = '0;
    #1;
    chk("reset_out_valid", 64'(out_valid_o), 64'd0);
    chk("reset_o", o_o, 64'd0);
    chk("reset_tag", 64'(tag_o), 64'd0);
    chk("reset_err", 64'(err_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready_o), 64'd1);
    step();

    // Directed ops and latency: offered in cycle n, visible after edge n+STAGES.
    out_ready_i = 1'b1;
    send(3'd2, 64'h8000_0000_0000_0000, 64'd0, 6'd4, 64'd0, 6'd1, 64'hF800_0000_0000_0000, 1'b0);
    @(negedge clk);
    chk("lat_early", 64'(out_valid_o), 64'd0);
    @(negedge clk);
    chk("lat_due", 64'(out_valid_o), 64'd1);
    step();
    send(3'd3, 64'h8000_0000_0000_0001, 64'd0, 6'd1, 64'd0, 6'd2, 64'h0000_0000_0000_0003, 1'b0);
    send(3'd5, 64'h0123_4567_89AB_CDEF, 64'd0, 6'd8, 64'hFF, 6'd3, 64'h0000_0000_0000_0001, 1'b0);
`ifdef RAPTOR64_SHIFT_FUNNEL_EN
    send(3'd7, 64'h1, 64'd0, 6'd4, 64'd0, 6'd4, 64'h1000_0000_0000_0000, 1'b0);
`else
    send(3'd7, 64'h1, 64'd0, 6'd4, 64'd0, 6'd4, 64'h0, 1'b1);
`endif
    drain();

    // Backpressure: capacity is STAGES, then in_ready_o drops and the head holds.
    out_ready_i = 1'b0;
    base    = emitted;
    accepts = 0;
    t       = 6'd1;
    m1      = model(3'd3, 64'h0123_4567_89AB_CDEF ^ 64'd1, 64'd0, 6'd1, 64'd0);
    for (int cyc = 0; cyc < 4; cyc++) begin
      logic [64:0] m;
      exp_t e;
      m = model(3'd3, 64'h0123_4567_89AB_CDEF ^ 64'(t), 64'd0, t, 64'd0);
      op_i = 3'd3; a_i = 64'h0123_4567_89AB_CDEF ^ 64'(t); c_i = '0; amt_i = t; mask_i = '0; tag_i = t;
      in_valid_i = 1'b1;
      @(negedge clk);
      if (cyc == 2) chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
      if (in_ready_o) begin
        e.tag = t; e.o = m[63:0]; e.err = m[64];
        sb.push_back(e);
        accepts++;
        t = t + 6'd1;
      end
      step();
    end
    in_valid_i = 1'b0;
    chk("bp_accepts", 64'(accepts), 64'd2);
    @(negedge clk);
    chk("bp_out_valid", 64'(out_valid_o), 64'd1);
    chk("bp_head_tag", 64'(tag_o), 64'd1);
    chk("bp_head_o", o_o, m1[63:0]);
    step();
    @(negedge clk);
    chk("bp_hold_o", o_o, m1[63:0]);
    chk("bp_hold_tag", 64'(tag_o), 64'd1);
    step();
    out_ready_i = 1'b1;
    for (int k = 3; k <= 4; k++) begin
      send_model(3'd3, 64'h0123_4567_89AB_CDEF ^ 64'(k), 64'd0, 6'(k), 64'd0, 6'(k));
    end
    drain();
    chk("bp_emitted", 64'(emitted - base), 64'd4);

    // Streaming with random consumer stalls; amt 0 and 63 first for every op.
    rand_rdy = 1'b1;
    base     = emitted;
    for (int i = 0; i < 100; i++) begin
      if (i < 16) begin
        rop  = 3'(i / 2);
        ramt = (i % 2 == 1) ? 6'd63 : 6'd0;
      end else begin
        rop  = 3'($urandom_range(0, 7));
        ramt = 6'($urandom_range(0, 63));
      end
      send_model(rop, {$urandom, $urandom}, {$urandom, $urandom}, ramt, {$urandom, $urandom}, 6'(i));
    end
    drain();
    chk("stream_emitted", 64'(emitted - base), 64'd100);
    rand_rdy    = 1'b0;
    out_ready_i = 1'b1;
    step();

    // Reset with two ops in flight: both are dropped silently.
    out_ready_i = 1'b0;
    send_model(3'd0, 64'hDEAD_BEEF_0000_0001, 64'd0, 6'd3, 64'd0, 6'd10);
    send_model(3'd4, 64'hCAFE_F00D_1234_5678, 64'd0, 6'd7, 64'd0, 6'd11);
    rst_ni = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_o", o_o, 64'd0);
    chk("midrst_tag", 64'(tag_o), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    base = emitted;
    repeat (6) @(negedge clk);
    chk("midrst_no_stale", 64'(emitted - base), 64'd0);
    chk("midrst_idle", 64'(out_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
